memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles a command is presented to memory (legal 1..15).
REQ-002 SHALL have port clk_i  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_i / req1_i  input  1  access request from requester 0 / 1.
REQ-005 SHALL have ports we0_i / we1_i  input  1  1 = write, 0 = read, for requester 0 / 1.
REQ-006 SHALL have ports addr0_i / addr1_i  input  32  word address for requester 0 / 1.
REQ-007 SHALL have ports wdata0_i / wdata1_i  input  32  write data for requester 0 / 1.
REQ-008 SHALL have ports ack0_o / ack1_o  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 SHALL have ports rdata0_o / rdata1_o  output  32  read data for requester 0 / 1, valid while matching ack is high.
REQ-010 SHALL have port mem_addr_o  output  32  address to the shared data memory.
REQ-011 SHALL have port mem_wdata_o  output  32  write data to memory.
REQ-012 SHALL have port mem_read_o  output  1  memory read strobe.
REQ-013 SHALL have port mem_write_o  output  1  memory write strobe.
REQ-014 SHALL have port mem_rdata_i  input  32  memory read data; valid at the posedge ending a read cycle.
REQ-015 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, ACCESS, RESP.
REQ-017 IDLE SHALL stay in IDLE when req0_i=req1_i=0.
REQ-018 IDLE with any request SHALL, at the posedge, latch winner id, we, addr and wdata, load the latency counter with MEM_LAT-1, and go to ACCESS.
REQ-019 When only one request is high, that requester SHALL win.
REQ-020 When both are high, the requester not granted last SHALL win; the last-granted pointer updates on every grant.
REQ-021 ACCESS SHALL drive mem_addr_o/mem_wdata_o from the latched command.
REQ-022 For reads, ACCESS SHALL hold mem_read_o=1 on every ACCESS cycle.
REQ-023 For writes, ACCESS SHALL assert mem_write_o only on the final ACCESS cycle (counter=0), giving exactly one write per grant.
REQ-024 ACCESS SHALL decrement the counter each cycle; at counter=0 it SHALL go to RESP.
REQ-025 On the ACCESS-to-RESP posedge of a read, mem_rdata_i SHALL be captured into the winner's rdata register.
REQ-026 A write SHALL leave both rdata registers unchanged.
REQ-027 RESP SHALL pulse the winner's ack for exactly one cycle, then go to IDLE.
REQ-028 ack0_o and ack1_o SHALL never be high together.
REQ-029 Latency SHALL be MEM_LAT+1 cycles from first IDLE cycle with req high to ack high; back-to-back grants are spaced MEM_LAT+2 cycles.
REQ-030 Requesters SHALL hold req/we/addr/wdata stable until ack, and SHALL deassert req or present a new command the cycle after ack.
REQ-031 The arbiter SHALL ignore requester input changes outside IDLE.
REQ-032 mem_read_o and mem_write_o SHALL be 0 outside ACCESS; mem_addr_o/mem_wdata_o hold their last latched value.
REQ-033 A request arriving during ACCESS/RESP of the other requester SHALL be served next with no starvation: at most one foreign grant precedes it.

Reset
REQ-034 rst_i high SHALL immediately force IDLE and clear the counter.
REQ-035 rst_i high SHALL immediately force ack0_o, ack1_o, mem_read_o, mem_write_o and busy_o to 0.
REQ-036 rst_i high SHALL immediately clear mem_addr_o, mem_wdata_o, rdata0_o and rdata1_o to 0.
REQ-037 rst_i high SHALL set the last-granted pointer so requester 0 wins the first tie.
REQ-038 A transaction interrupted by reset SHALL never be acked; a pending write not yet at its final cycle SHALL never strobe.

Verification
REQ-039 Single read, MEM_LAT=1: req0 read addr 3 with memory word 3 = 0xDEADBEEF -> mem_read_o high 1 cycle, ack0_o at cycle 2, rdata0_o=0xDEADBEEF.
REQ-040 Write-then-read: req1 write addr 5 data 0x12345678, then read addr 5 -> exactly one mem_write_o pulse; ack1_o returns rdata1_o=0x12345678.
REQ-041 Tie after reset: req0 and req1 both high continuously -> grant order 0,1,0,1; acks every 3 cycles, alternating.
REQ-042 MEM_LAT=3 read -> mem_read_o high 3 cycles; ack at cycle 4; busy_o high cycles 1-4.
REQ-043 Reset mid-ACCESS of a MEM_LAT=3 write at cycle 2 -> strobes drop immediately, no mem_write_o, no ack; the next tie is granted to requester 0.
REQ-044 req1 rises while requester 0 is in ACCESS -> requester 1 is granted in the IDLE after RESP, even with req0 reasserted.

Source files
------------

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-requester round-robin arbiter for one shared data memory
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req0_i/req1_i                 access request from requester 0 / 1
//   we0_i/we1_i                   1 = write, 0 = read
//   addr0_i/addr1_i               word address
//   wdata0_i/wdata1_i             write data
//   ack0_o/ack1_o                 one-cycle completion pulse
//   rdata0_o/rdata1_o             read data, valid while the matching ack is high
//   mem_addr_o/mem_wdata_o        latched command towards memory
//   mem_read_o/mem_write_o        memory strobes, only ever high in ACCESS
//   mem_rdata_i                   memory read data, sampled at the end of a read
//   busy_o                        high whenever the arbiter is not IDLE
//
// MEM_LAT (1..15) is the number of ACCESS cycles a command is presented to memory.

module memory_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_id;   // requester granted most recently
  logic        cur_id;    // requester owning the current transaction
  logic        cur_we;

  logic        grant_id;
  logic        grant_we;
  logic [31:0] grant_addr;
  logic [31:0] grant_wdata;

  // On a tie the requester that was not granted last wins, so a requester
  // that shows up while the other one is being served is always next.
  always_comb begin
    grant_id = 1'b0;
    if (req0_i && req1_i) begin
      grant_id = ~last_id;
    end else if (req1_i) begin
      grant_id = 1'b1;
    end
    grant_we    = grant_id ? we1_i    : we0_i;
    grant_addr  = grant_id ? addr1_i  : addr0_i;
    grant_wdata = grant_id ? wdata1_i : wdata0_i;
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_id     <= 1'b1;  // requester 0 wins the first tie
      cur_id      <= 1'b0;
      cur_we      <= 1'b0;
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      rdata0_o    <= 32'd0;
      rdata1_o    <= 32'd0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
    end else begin
      // Strobes and acks are pulses; each state re-asserts what it needs.
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_i || req1_i) begin
            cur_id      <= grant_id;
            last_id     <= grant_id;
            cur_we      <= grant_we;
            mem_addr_o  <= grant_addr;
            mem_wdata_o <= grant_wdata;
            cnt         <= LAT_INIT;
            state       <= ACCESS;
            mem_read_o  <= ~grant_we;
            // With a one-cycle access the first ACCESS cycle is also the last.
            mem_write_o <= grant_we && (LAT_INIT == 4'd0);
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (!cur_we) begin
              if (cur_id) begin
                rdata1_o <= mem_rdata_i;
              end else begin
                rdata0_o <= mem_rdata_i;
              end
            end
            ack0_o <= ~cur_id;
            ack1_o <= cur_id;
          end else begin
            cnt         <= cnt - 4'd1;
            mem_read_o  <= ~cur_we;
            // The write strobe lands on the cycle where the counter reads 0,
            // so a write cut short by reset never reaches memory.
            mem_write_o <= cur_we && (cnt == 4'd1);
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter at MEM_LAT 1 and 3

module tb_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]       req0, req1, we0, we1, ack0, ack1, mem_read, mem_write, busy;
  logic [1:0][31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1, mem_addr, mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt[2];
  int wr_cnt[2];
  int busy_cnt[2];

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  // One expectation queue per (instance, requester): index g*2 + side.
  exp_t sb[4][$];

  // Instance 0 runs with MEM_LAT=1, instance 1 with MEM_LAT=3.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [16];
    logic [31:0] mrd;

    assign mrd = mem[mem_addr[g][3:0]];

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        mem[3] <= 32'hDEAD_BEEF;
      end else if (mem_write[g]) begin
        mem[mem_addr[g][3:0]] <= mem_wdata[g];
      end
    end

    memory_arbiter #(.MEM_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req0_i      (req0[g]),
      .req1_i      (req1[g]),
      .we0_i       (we0[g]),
      .we1_i       (we1[g]),
      .addr0_i     (addr0[g]),
      .addr1_i     (addr1[g]),
      .wdata0_i    (wdata0[g]),
      .wdata1_i    (wdata1[g]),
      .ack0_o      (ack0[g]),
      .ack1_o      (ack1[g]),
      .rdata0_o    (rdata0[g]),
      .rdata1_o    (rdata1[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_read_o  (mem_read[g]),
      .mem_write_o (mem_write[g]),
      .mem_rdata_i (mrd),
      .busy_o      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input int g, input int side, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (side == 0) begin
      req0[g] = r; we0[g] = w; addr0[g] = a; wdata0[g] = d;
    end else begin
      req1[g] = r; we1[g] = w; addr1[g] = a; wdata1[g] = d;
    end
  endtask

  // Present one command, hold it until its ack, then drop it after the ack cycle.
  task automatic do_req(input int g, input int side, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_cyc);
    exp_t e;
    bit   got;
    e.rd   = ~w;
    e.data = exp_rd;
    e.cyc  = exp_cyc;
    sb[g * 2 + side].push_back(e);
    drive(g, side, 1'b1, w, a, d);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (side == 0) ? ack0[g] : ack1[g];
    end
    if (!got) check($sformatf("ack_timeout_i%0d_r%0d", g, side), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    drive(g, side, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: counts strobes and pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        if (mem_read[g])  rd_cnt[g]++;
        if (mem_write[g]) wr_cnt[g]++;
        if (busy[g])      busy_cnt[g]++;
        if (ack0[g] || ack1[g]) begin
          check($sformatf("ack_exclusive_i%0d", g), 32'(ack0[g] & ack1[g]), 32'd0);
          for (int s = 0; s < 2; s++) begin
            exp_t e;
            int   k;
            k = g * 2 + s;
            if ((s == 0) ? ack0[g] : ack1[g]) begin
              if (sb[k].size() == 0) begin
                check($sformatf("unexpected_ack_i%0d_r%0d", g, s), 32'd1, 32'd0);
              end else begin
                e = sb[k].pop_front();
                check($sformatf("ack_cycle_i%0d_r%0d", g, s), 32'(cyc), 32'(e.cyc));
                if (e.rd)
                  check($sformatf("rdata_i%0d_r%0d", g, s),
                        (s == 0) ? rdata0[g] : rdata1[g], e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, s_rd, s_wr, s_busy;
    rst = 1'b1;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_ack0_i%0d", g),      32'(ack0[g]), 32'd0);
      check($sformatf("rst_ack1_i%0d", g),      32'(ack1[g]), 32'd0);
      check($sformatf("rst_busy_i%0d", g),      32'(busy[g]), 32'd0);
      check($sformatf("rst_mem_read_i%0d", g),  32'(mem_read[g]), 32'd0);
      check($sformatf("rst_mem_write_i%0d", g), 32'(mem_write[g]), 32'd0);
      check($sformatf("rst_mem_addr_i%0d", g),  mem_addr[g], 32'd0);
      check($sformatf("rst_mem_wdata_i%0d", g), mem_wdata[g], 32'd0);
      check($sformatf("rst_rdata0_i%0d", g),    rdata0[g], 32'd0);
      check($sformatf("rst_rdata1_i%0d", g),    rdata1[g], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single read, MEM_LAT=1.
    s_rd = rd_cnt[0]; s_busy = busy_cnt[0];
    do_req(0, 0, 1'b0, 32'd3, 32'd0, 32'hDEAD_BEEF, cyc + 2);
    check("lat1_read_cycles", 32'(rd_cnt[0] - s_rd), 32'd1);
    check("lat1_busy_cycles", 32'(busy_cnt[0] - s_busy), 32'd2);

    // Write then read back on requester 1.
    s_wr = wr_cnt[0];
    do_req(0, 1, 1'b1, 32'd5, 32'h1234_5678, 32'd0, cyc + 2);
    do_req(0, 1, 1'b0, 32'd5, 32'd0, 32'h1234_5678, cyc + 2);
    check("lat1_write_pulses", 32'(wr_cnt[0] - s_wr), 32'd1);

    // Continuous tie after reset: 0,1,0,1 with acks 3 cycles apart.
    pulse_reset();
    c = cyc;
    fork
      begin
        do_req(0, 0, 1'b0, 32'd1, 32'd0, 32'hA000_0001, c + 2);
        do_req(0, 0, 1'b0, 32'd2, 32'd0, 32'hA000_0002, c + 8);
      end
      begin
        do_req(0, 1, 1'b0, 32'd4, 32'd0, 32'hA000_0004, c + 5);
        do_req(0, 1, 1'b0, 32'd6, 32'd0, 32'hA000_0006, c + 11);
      end
    join

    // MEM_LAT=3 read.
    s_rd = rd_cnt[1]; s_busy = busy_cnt[1];
    do_req(1, 0, 1'b0, 32'd7, 32'd0, 32'hA000_0007, cyc + 4);
    check("lat3_read_cycles", 32'(rd_cnt[1] - s_rd), 32'd3);
    check("lat3_busy_cycles", 32'(busy_cnt[1] - s_busy), 32'd4);

    // Reset during the second ACCESS cycle of a MEM_LAT=3 write.
    s_wr = wr_cnt[1];
    drive(1, 0, 1'b1, 1'b1, 32'd9, 32'h0000_0055);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_busy_before_rst", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",      32'(busy[1]), 32'd0);
    check("mid_rst_mem_write", 32'(mem_write[1]), 32'd0);
    check("mid_rst_mem_read",  32'(mem_read[1]), 32'd0);
    check("mid_rst_ack0",      32'(ack0[1]), 32'd0);
    check("mid_rst_mem_addr",  mem_addr[1], 32'd0);
    check("mid_rst_mem_wdata", mem_wdata[1], 32'd0);
    drive(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_write", 32'(wr_cnt[1] - s_wr), 32'd0);

    // First tie after that reset goes to requester 0.
    c = cyc;
    fork
      do_req(1, 0, 1'b0, 32'd1, 32'd0, 32'hA000_0001, c + 4);
      do_req(1, 1, 1'b0, 32'd2, 32'd0, 32'hA000_0002, c + 9);
    join

    // req1 arrives during requester 0's ACCESS; it must beat req0's next command.
    c = cyc;
    fork
      begin
        do_req(1, 0, 1'b0, 32'd2, 32'd0, 32'hA000_0002, c + 4);
        do_req(1, 0, 1'b0, 32'd4, 32'd0, 32'hA000_0004, c + 14);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        do_req(1, 1, 1'b0, 32'd6, 32'd0, 32'hA000_0006, c + 9);
      end
    join

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("scoreboard_drained_%0d", k), 32'(sb[k].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
